// File: rtl/irq_pkg.sv
// Shared types and constants for the bus-mapped interrupt controller.
package irq_pkg;

    localparam int unsigned MAX_SOURCES = 8;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned ID_W        = 3;
    localparam int unsigned OFS_W       = 2;

    localparam logic [OFS_W-1:0] OFS_MASK = 2'd0;
    localparam logic [OFS_W-1:0] OFS_PEND = 2'd1;
    localparam logic [OFS_W-1:0] OFS_ID   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        ACK    = 2'd2
    } irq_state_e;

    // Bit mask of the implemented source positions within a data byte.
    function automatic logic [DATA_W-1:0] src_mask(input int unsigned n);
        return DATA_W'((1 << n) - 1);
    endfunction

endpackage

// File: rtl/irq_priority_sel.sv
// Picks one eligible interrupt source; IRQ_ROUND_ROBIN_EN selects rotating
// priority, otherwise the lowest eligible index wins.
module irq_priority_sel
    import irq_pkg::*;
#(
    parameter int unsigned NUM_SOURCES = 2
) (
    input  logic [MAX_SOURCES-1:0] eligible_i,
    input  logic [ID_W-1:0]        last_id_i,
    output logic                   valid_c_o,
    output logic [ID_W-1:0]        idx_c_o
);

`ifdef IRQ_ROUND_ROBIN_EN
    // Search begins just after the last serviced source and wraps once.
    always_comb begin
        int unsigned j;
        valid_c_o = 1'b0;
        idx_c_o   = '0;
        j         = 0;
        for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
            j = int'(last_id_i) + 1 + k;
            if (j >= NUM_SOURCES) begin
                j = j - NUM_SOURCES;
            end
            if (!valid_c_o && eligible_i[ID_W'(j)]) begin
                valid_c_o = 1'b1;
                idx_c_o   = ID_W'(j);
            end
        end
    end

    // Positions above NUM_SOURCES are held at zero by the register file.
    logic unused_sel;
    assign unused_sel = ^eligible_i;
`else
    always_comb begin
        valid_c_o = 1'b0;
        idx_c_o   = '0;
        for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
            if (!valid_c_o && eligible_i[ID_W'(i)]) begin
                valid_c_o = 1'b1;
                idx_c_o   = ID_W'(i);
            end
        end
    end

    // Fixed priority has no use for history; upper eligible bits are always zero.
    logic unused_sel;
    assign unused_sel = ^{last_id_i, eligible_i};
`endif

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge-latched pending bits, mask, CPU handshake FSM and
// a 3-byte bus register window. IRQ_ROUND_ROBIN_EN enables rotating priority.
module irq_controller
    import irq_pkg::*;
#(
    parameter logic [7:0]  BaseAddr    = 8'hE0,
    parameter int unsigned NUM_SOURCES = 2,
    parameter logic [7:0]  InitialMask = 8'hFF
) (
    input  logic                   CLK,
    input  logic                   RESET,
    inout  wire  [DATA_W-1:0]      BUS_DATA,
    input  logic [7:0]             BUS_ADDR,
    input  logic                   BUS_WE,
    input  logic [NUM_SOURCES-1:0] IRQ_RAISE,
    output logic [NUM_SOURCES-1:0] IRQ_ACK,
    output logic                   CPU_INT,
    output logic [ID_W-1:0]        CPU_INT_ID,
    input  logic                   CPU_INT_ACK
);

    localparam logic [DATA_W-1:0] SRC_MASK = src_mask(NUM_SOURCES);
    localparam int unsigned       WIN_SIZE = 3;

    irq_state_e state_q, state_d;

    logic [NUM_SOURCES-1:0] raise_q;
    logic [DATA_W-1:0]      pending_q, pending_d;
    logic [DATA_W-1:0]      mask_q, mask_d;
    logic [ID_W-1:0]        last_id_q, last_id_d;
    logic                   cpu_int_q, cpu_int_d;
    logic [ID_W-1:0]        cpu_id_q, cpu_id_d;
    logic [NUM_SOURCES-1:0] irq_ack_q, irq_ack_d;
    logic                   rd_en_q;
    logic [OFS_W-1:0]       rd_ofs_q;

    logic [8:0]        addr_ofs_c;
    logic              in_win_c;
    logic [OFS_W-1:0]  ofs_c;
    logic              wr_mask_c, wr_pend_c, rd_c;
    logic [DATA_W-1:0] rise_c, eligible_c, ack_vec_c, rd_data_c;
    logic              sel_valid_c, ack_fire_c;
    logic [ID_W-1:0]   sel_idx_c;

    // Address decode; 9-bit subtraction keeps the window from wrapping.
    assign addr_ofs_c = {1'b0, BUS_ADDR} - {1'b0, BaseAddr};
    assign in_win_c   = (addr_ofs_c < 9'(WIN_SIZE));
    assign ofs_c      = addr_ofs_c[OFS_W-1:0];
    assign wr_mask_c  = in_win_c && BUS_WE && (ofs_c == OFS_MASK);
    assign wr_pend_c  = in_win_c && BUS_WE && (ofs_c == OFS_PEND);
    assign rd_c       = in_win_c && !BUS_WE;

    assign rise_c     = DATA_W'(IRQ_RAISE & ~raise_q);
    assign eligible_c = pending_q & mask_q;
    assign ack_vec_c  = DATA_W'(1) << cpu_id_q;

    irq_priority_sel #(
        .NUM_SOURCES (NUM_SOURCES)
    ) u_sel (
        .eligible_i (eligible_c),
        .last_id_i  (last_id_q),
        .valid_c_o  (sel_valid_c),
        .idx_c_o    (sel_idx_c)
    );

    // Handshake FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and registered-output next values.
    always_comb begin
        state_d    = state_q;
        cpu_int_d  = cpu_int_q;
        cpu_id_d   = cpu_id_q;
        irq_ack_d  = '0;
        ack_fire_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_valid_c) begin
                    state_d   = ASSERT;
                    cpu_int_d = 1'b1;
                    cpu_id_d  = sel_idx_c;
                end
            end
            ASSERT: begin
                if (CPU_INT_ACK) begin
                    state_d    = ACK;
                    cpu_int_d  = 1'b0;
                    irq_ack_d  = NUM_SOURCES'(ack_vec_c);
                    ack_fire_c = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A fresh rising edge is applied last so it beats both clear paths.
    always_comb begin
        pending_d = pending_q;
        if (wr_pend_c) begin
            pending_d = pending_d & ~BUS_DATA;
        end
        if (ack_fire_c) begin
            pending_d = pending_d & ~ack_vec_c;
        end
        pending_d = (pending_d | rise_c) & SRC_MASK;
        mask_d    = wr_mask_c ? (BUS_DATA & SRC_MASK) : mask_q;
        last_id_d = ack_fire_c ? cpu_id_q : last_id_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            raise_q   <= '0;
            pending_q <= '0;
            mask_q    <= InitialMask & SRC_MASK;
            last_id_q <= ID_W'(NUM_SOURCES - 1);
            cpu_int_q <= 1'b0;
            cpu_id_q  <= '0;
            irq_ack_q <= '0;
            rd_en_q   <= 1'b0;
            rd_ofs_q  <= '0;
        end else begin
            raise_q   <= IRQ_RAISE;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            last_id_q <= last_id_d;
            cpu_int_q <= cpu_int_d;
            cpu_id_q  <= cpu_id_d;
            irq_ack_q <= irq_ack_d;
            rd_en_q   <= rd_c;
            rd_ofs_q  <= ofs_c;
        end
    end

    // Read data reflects register contents during the drive cycle.
    always_comb begin
        rd_data_c = '0;
        case (rd_ofs_q)
            OFS_MASK: rd_data_c = mask_q;
            OFS_PEND: rd_data_c = pending_q;
            OFS_ID:   rd_data_c = DATA_W'(cpu_id_q);
            default:  rd_data_c = '0;
        endcase
    end

    assign BUS_DATA   = rd_en_q ? rd_data_c : {DATA_W{1'bz}};
    assign IRQ_ACK    = irq_ack_q;
    assign CPU_INT    = cpu_int_q;
    assign CPU_INT_ID = cpu_id_q;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: stimulus queues expected events with the
// cycle they are due; a negedge monitor pops and compares them.
module tb_irq_controller;

    localparam logic [7:0]  BASE = 8'hE0;
    localparam int unsigned NS   = 2;
`ifdef IRQ_ROUND_ROBIN_EN
    localparam int unsigned FIRST = 1;
`else
    localparam int unsigned FIRST = 0;
`endif

    logic          clk;
    logic          rst;
    logic [7:0]    bus_addr;
    logic          bus_we;
    logic [NS-1:0] raise;
    logic [NS-1:0] irq_ack;
    logic          cpu_int;
    logic [2:0]    cpu_id;
    logic          cpu_ack;
    logic          tb_drv;
    logic [7:0]    tb_wdata;
    tri1  [7:0]    bus_data;

    assign bus_data = tb_drv ? tb_wdata : 8'bz;

    irq_controller #(
        .BaseAddr    (BASE),
        .NUM_SOURCES (NS),
        .InitialMask (8'hFF)
    ) dut (
        .CLK         (clk),
        .RESET       (rst),
        .BUS_DATA    (bus_data),
        .BUS_ADDR    (bus_addr),
        .BUS_WE      (bus_we),
        .IRQ_RAISE   (raise),
        .IRQ_ACK     (irq_ack),
        .CPU_INT     (cpu_int),
        .CPU_INT_ID  (cpu_id),
        .CPU_INT_ACK (cpu_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    exp_t q_int[$];
    exp_t q_ack[$];
    exp_t q_bus[$];
    exp_t q_lvl[$];

    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    logic done        = 1'b0;
    logic prev_int    = 1'b0;
    logic int_rise;
    logic has;
    exp_t e;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: outputs are stable at the falling edge.
    always @(negedge clk) begin
        int_rise = cpu_int && !prev_int;
        has = (q_int.size() > 0) && (q_int[0].cyc == cyc);
        if (int_rise || has) begin
            vectors++;
            if (!has) begin
                miscompares++;
                $display("FAIL int_present cyc=%0d: got new request id=%0d, required none", cyc, cpu_id);
            end else begin
                e = q_int.pop_front();
                if (!int_rise || cpu_id !== e.val[2:0]) begin
                    miscompares++;
                    $display("FAIL int_present cyc=%0d: got rise=%0b id=%0d, required rise=1 id=%0d",
                             cyc, int_rise, cpu_id, e.val[2:0]);
                end
            end
        end
        prev_int = cpu_int;

        has = (q_ack.size() > 0) && (q_ack[0].cyc == cyc);
        if ((irq_ack != '0) || has) begin
            vectors++;
            if (!has) begin
                miscompares++;
                $display("FAIL ack_pulse cyc=%0d: got IRQ_ACK=%b, required 00", cyc, irq_ack);
            end else begin
                e = q_ack.pop_front();
                if (irq_ack !== e.val[NS-1:0]) begin
                    miscompares++;
                    $display("FAIL ack_pulse cyc=%0d: got IRQ_ACK=%b, required %b", cyc, irq_ack, e.val[NS-1:0]);
                end
            end
        end

        if ((q_bus.size() > 0) && (q_bus[0].cyc == cyc)) begin
            e = q_bus.pop_front();
            vectors++;
            if (bus_data !== e.val) begin
                miscompares++;
                $display("FAIL bus_read cyc=%0d: got BUS_DATA=%h, required %h (ff = released)", cyc, bus_data, e.val);
            end
        end

        if ((q_lvl.size() > 0) && (q_lvl[0].cyc == cyc)) begin
            e = q_lvl.pop_front();
            vectors++;
            if ({irq_ack, cpu_int} !== e.val[2:0]) begin
                miscompares++;
                $display("FAIL out_level cyc=%0d: got CPU_INT=%b IRQ_ACK=%b, required CPU_INT=%b IRQ_ACK=%b",
                         cyc, cpu_int, irq_ack, e.val[0], e.val[2:1]);
            end
        end

        if (done) begin
            foreach (q_int[i]) begin
                vectors++; miscompares++;
                $display("FAIL int_missing: no request seen, required id=%0d at cyc=%0d", q_int[i].val[2:0], q_int[i].cyc);
            end
            foreach (q_ack[i]) begin
                vectors++; miscompares++;
                $display("FAIL ack_missing: no pulse seen, required %b at cyc=%0d", q_ack[i].val[NS-1:0], q_ack[i].cyc);
            end
            foreach (q_bus[i]) begin
                vectors++; miscompares++;
                $display("FAIL bus_missing: not sampled, required %h at cyc=%0d", q_bus[i].val, q_bus[i].cyc);
            end
            foreach (q_lvl[i]) begin
                vectors++; miscompares++;
                $display("FAIL lvl_missing: not sampled at cyc=%0d", q_lvl[i].cyc);
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_int(input int dc, input logic [2:0] id);
        q_int.push_back('{cyc + dc, {5'b0, id}});
    endtask

    task automatic expect_ack(input int dc, input logic [NS-1:0] v);
        q_ack.push_back('{cyc + dc, 8'(v)});
    endtask

    task automatic expect_bus(input int dc, input logic [7:0] v);
        q_bus.push_back('{cyc + dc, v});
    endtask

    task automatic expect_lvl(input int dc, input logic int_v, input logic [NS-1:0] ack_v);
        q_lvl.push_back('{cyc + dc, 8'({ack_v, int_v})});
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        bus_addr = addr;
        bus_we   = 1'b1;
        tb_wdata = data;
        tb_drv   = 1'b1;
        step(1);
        bus_we   = 1'b0;
        tb_drv   = 1'b0;
        bus_addr = 8'h00;
    endtask

    // Read data appears the cycle after the address edge; a spare cycle follows.
    task automatic bus_read(input logic [7:0] addr, input logic [7:0] v);
        bus_addr = addr;
        bus_we   = 1'b0;
        expect_bus(1, v);
        step(1);
        bus_addr = 8'h00;
        step(1);
    endtask

    task automatic pair(input int unsigned first, input int unsigned second);
        raise = 2'b11;
        expect_int(2, 3'(first));
        step(2);
        cpu_ack = 1'b1;
        expect_ack(1, NS'(1) << first);
        step(1);
        cpu_ack = 1'b0;
        expect_int(2, 3'(second));
        step(2);
        cpu_ack = 1'b1;
        expect_ack(1, NS'(1) << second);
        step(1);
        cpu_ack = 1'b0;
        raise   = 2'b00;
        step(2);
    endtask

    initial begin
        rst      = 1'b1;
        bus_addr = BASE;
        bus_we   = 1'b0;
        raise    = '0;
        cpu_ack  = 1'b0;
        tb_drv   = 1'b0;
        tb_wdata = 8'h00;
        step(2);
        // Reset: outputs idle and bus released even with a read address present.
        expect_lvl(1, 1'b0, 2'b00);
        expect_bus(1, 8'hFF);
        step(1);
        rst      = 1'b0;
        bus_addr = 8'h00;
        step(1);
        bus_read(BASE + 8'd0, 8'h03);
        bus_read(BASE + 8'd1, 8'h00);
        bus_read(BASE + 8'd2, 8'h00);
        bus_read(BASE + 8'd3, 8'hFF);
        bus_read(BASE - 8'd1, 8'hFF);

        // Single source, held high, acked 3 cycles after the request.
        raise = 2'b01;
        expect_int(2, 3'd0);
        step(3);
        expect_lvl(1, 1'b1, 2'b00);
        step(1);
        cpu_ack = 1'b1;
        expect_ack(1, 2'b01);
        expect_lvl(1, 1'b0, 2'b01);
        step(1);
        cpu_ack = 1'b0;
        raise   = 2'b00;
        expect_lvl(1, 1'b0, 2'b00);
        step(3);
        bus_read(BASE + 8'd1, 8'h00);

        // Simultaneous pairs.
        pair(FIRST, 1 - FIRST);
        pair(FIRST, 1 - FIRST);

        // Masked source stays pending until unmasked.
        bus_write(BASE + 8'd0, 8'h01);
        raise = 2'b10;
        expect_lvl(3, 1'b0, 2'b00);
        step(1);
        bus_read(BASE + 8'd1, 8'h02);
        expect_int(2, 3'd1);
        bus_write(BASE + 8'd0, 8'h03);
        bus_read(BASE + 8'd2, 8'h01);
        bus_read(BASE + 8'd0, 8'h03);
        cpu_ack = 1'b1;
        expect_ack(1, 2'b10);
        step(1);
        cpu_ack = 1'b0;
        raise   = 2'b00;
        step(2);

        // Write-1-to-clear, and a new edge beating it in the same cycle.
        bus_write(BASE + 8'd0, 8'h00);
        raise = 2'b10;
        step(1);
        raise = 2'b00;
        step(1);
        bus_read(BASE + 8'd1, 8'h02);
        bus_write(BASE + 8'd1, 8'h02);
        bus_read(BASE + 8'd1, 8'h00);
        raise = 2'b10;
        bus_write(BASE + 8'd1, 8'h02);
        raise = 2'b00;
        bus_read(BASE + 8'd1, 8'h02);
        bus_write(BASE + 8'd3, 8'hFF);
        bus_write(BASE - 8'd1, 8'hFF);
        bus_read(BASE + 8'd0, 8'h00);
        expect_int(2, 3'd1);
        bus_write(BASE + 8'd0, 8'hFF);
        bus_read(BASE + 8'd0, 8'h03);
        cpu_ack = 1'b1;
        expect_ack(1, 2'b10);
        step(1);
        cpu_ack = 1'b0;
        step(2);

        // A new edge beats the acknowledge clear: source 0 is presented again.
        raise = 2'b01;
        expect_int(2, 3'd0);
        step(1);
        raise = 2'b00;
        step(2);
        cpu_ack = 1'b1;
        raise   = 2'b01;
        expect_ack(1, 2'b01);
        expect_int(3, 3'd0);
        step(1);
        cpu_ack = 1'b0;
        step(2);
        cpu_ack = 1'b1;
        expect_ack(1, 2'b01);
        step(1);
        cpu_ack = 1'b0;
        raise   = 2'b00;
        step(2);

        // Reset while a request is presented, with an ack pending on the same edge.
        bus_write(BASE + 8'd0, 8'h01);
        raise = 2'b01;
        expect_int(2, 3'd0);
        step(3);
        rst      = 1'b1;
        cpu_ack  = 1'b1;
        raise    = 2'b00;
        bus_addr = BASE;
        expect_lvl(1, 1'b0, 2'b00);
        expect_bus(1, 8'hFF);
        step(1);
        cpu_ack = 1'b0;
        expect_lvl(1, 1'b0, 2'b00);
        expect_bus(1, 8'hFF);
        step(1);
        rst      = 1'b0;
        bus_addr = 8'h00;
        expect_lvl(3, 1'b0, 2'b00);
        step(1);
        bus_read(BASE + 8'd0, 8'h03);
        bus_read(BASE + 8'd1, 8'h00);
        bus_read(BASE + 8'd2, 8'h00);

        step(4);
        done = 1'b1;
        step(4);
    end

endmodule
